// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle shared by the register bank and its host.
// master drives sclk/ncs/copi; slave drives cipo/cipo_oe.
interface spi_reg_bank_if;
    logic sclk;
    logic ncs;
    logic copi;
    logic cipo;
    logic cipo_oe;

    modport master (
        output sclk, ncs, copi,
        input  cipo, cipo_oe
    );

    modport slave (
        input  sclk, ncs, copi,
        output cipo, cipo_oe
    );
endinterface

// File: rtl/spi_reg_bank.sv
// SPI mode-0 register bank: validated writes, CIPO read-back, flat reg bus.
// Define SPI_REG_BANK_ERR_CNT_EN to add the saturating rejected-frame counter err_cnt.
module spi_reg_bank #(
    parameter int                ADDR_W      = 7,
    parameter int                DATA_W      = 8,
    parameter int                NUM_REGS    = 5,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0,
    parameter int                SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    spi_reg_bank_if.slave              spi,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       busy
`ifdef SPI_REG_BANK_ERR_CNT_EN
    ,
    output logic [7:0]                 err_cnt
`endif
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
    localparam logic [ADDR_W:0]  NREGS    = (ADDR_W+1)'(NUM_REGS);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    logic [SYNC_STAGES:0]   sclk_q, sclk_d;
    logic [SYNC_STAGES:0]   ncs_q, ncs_d;
    logic [SYNC_STAGES-1:0] copi_q, copi_d;
    logic sclk_rise, sclk_fall, ncs_rise, ncs_fall, copi_s;

    logic [1:0]                 state_q, state_d;
    logic [CNT_W-1:0]           bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]         sr_q, sr_d;
    logic [DATA_W-1:0]          out_sr_q, out_sr_d;
    logic                       cipo_q, cipo_d;
    logic                       cipo_oe_q, cipo_oe_d;
    logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
    logic                       wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;

    logic [FRAME_W-1:0] shifted;
    logic               f_rw, f_ok, commit;
    logic [ADDR_W-1:0]  f_addr;
    logic [DATA_W-1:0]  f_data, rd_val;
    int                 f_idx, h_idx;

    // Top chain bit is the edge-detect flop; the one below it is the synced value.
    always_comb begin
        sclk_d    = {sclk_q[SYNC_STAGES-1:0], spi.sclk};
        ncs_d     = {ncs_q[SYNC_STAGES-1:0], spi.ncs};
        copi_d    = {copi_q[SYNC_STAGES-2:0], spi.copi};
        sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
        sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
        ncs_rise  = ncs_q[SYNC_STAGES-1] & ~ncs_q[SYNC_STAGES];
        ncs_fall  = ~ncs_q[SYNC_STAGES-1] & ncs_q[SYNC_STAGES];
        copi_s    = copi_q[SYNC_STAGES-1];
    end

    always_comb begin
        f_rw    = sr_q[FRAME_W-1];
        f_addr  = sr_q[DATA_W +: ADDR_W];
        f_data  = sr_q[DATA_W-1:0];
        f_idx   = 32'(f_addr);
        f_ok    = (bit_cnt_q == CNT_FULL) && ({1'b0, f_addr} < NREGS);
        commit  = (state_q == ST_COMMIT) && f_ok && f_rw;
        shifted = {sr_q[FRAME_W-2:0], copi_s};
        h_idx   = 32'(shifted[ADDR_W-1:0]);
        rd_val  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (h_idx == i) rd_val = regs_q[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sr_d        = sr_q;
        out_sr_d    = out_sr_q;
        cipo_d      = cipo_q;
        cipo_oe_d   = cipo_oe_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ncs_fall) begin
                    state_d   = ST_ACTIVE;
                    bit_cnt_d = '0;
                    sr_d      = '0;
                    out_sr_d  = '0;
                end
            end
            ST_ACTIVE: begin
                if (ncs_rise) begin
                    state_d   = ST_COMMIT;
                    cipo_d    = 1'b0;
                    cipo_oe_d = 1'b0;
                    out_sr_d  = '0;
                end else begin
                    if (sclk_rise) begin
                        sr_d = shifted;
                        if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        // Header just completed: preload read data.
                        if (bit_cnt_q == CNT_HDR && !shifted[ADDR_W]) begin
                            out_sr_d  = rd_val;
                            cipo_oe_d = 1'b1;
                        end
                    end
                    if (sclk_fall && cipo_oe_q) begin
                        cipo_d   = out_sr_q[DATA_W-1];
                        out_sr_d = out_sr_q << 1;
                    end
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                if (commit) begin
                    wr_strobe_d = 1'b1;
                    wr_addr_d   = f_addr;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (f_idx == i) regs_d[i*DATA_W +: DATA_W] = f_data;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q      <= '0;
            ncs_q       <= '1;
            copi_q      <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            sr_q        <= '0;
            out_sr_q    <= '0;
            cipo_q      <= 1'b0;
            cipo_oe_q   <= 1'b0;
            regs_q      <= {NUM_REGS{RESET_VAL}};
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            sclk_q      <= sclk_d;
            ncs_q       <= ncs_d;
            copi_q      <= copi_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            out_sr_q    <= out_sr_d;
            cipo_q      <= cipo_d;
            cipo_oe_q   <= cipo_oe_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

`ifdef SPI_REG_BANK_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // A zero-length frame (ncs glitch) is not counted.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (state_q == ST_COMMIT && bit_cnt_q != '0 && !f_ok && err_cnt_q != 8'hff)
            err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

    assign spi.cipo    = cipo_q;
    assign spi.cipo_oe = cipo_oe_q;
    assign regs_flat   = regs_q;
    assign wr_strobe   = wr_strobe_q;
    assign wr_addr     = wr_addr_q;
    assign busy        = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: default build (a) and ADDR_W=3/DATA_W=12/NUM_REGS=8 build (b).
// Directed frames then random frames, checked against an array model.
module tb_spi_reg_bank;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_reg_bank_if sif_a ();
    spi_reg_bank_if sif_b ();

    logic [39:0] regs_a;
    logic [95:0] regs_b;
    logic        strb_a, strb_b, busy_a, busy_b;
    logic [6:0]  wa_a;
    logic [2:0]  wa_b;
`ifdef SPI_REG_BANK_ERR_CNT_EN
    logic [7:0]  err_a, err_b;
`endif

    spi_reg_bank u_a (
        .clk(clk), .rst_n(rst_n), .spi(sif_a), .regs_flat(regs_a),
        .wr_strobe(strb_a), .wr_addr(wa_a), .busy(busy_a)
`ifdef SPI_REG_BANK_ERR_CNT_EN
        , .err_cnt(err_a)
`endif
    );

    spi_reg_bank #(.ADDR_W(3), .DATA_W(12), .NUM_REGS(8)) u_b (
        .clk(clk), .rst_n(rst_n), .spi(sif_b), .regs_flat(regs_b),
        .wr_strobe(strb_b), .wr_addr(wa_b), .busy(busy_b)
`ifdef SPI_REG_BANK_ERR_CNT_EN
        , .err_cnt(err_b)
`endif
    );

    int checks = 0;
    int failures = 0;
    int strb_cnt_a = 0;
    int strb_cnt_b = 0;

    always @(posedge clk) begin
        if (strb_a) strb_cnt_a <= strb_cnt_a + 1;
        if (strb_b) strb_cnt_b <= strb_cnt_b + 1;
    end

    logic [7:0]  ma [5];
    logic [11:0] mb [8];
    int          exp_wa [2];
    int          exp_err [2];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pins(input int d, input logic s, input logic n, input logic c);
        if (d == 0) begin
            sif_a.sclk = s; sif_a.ncs = n; sif_a.copi = c;
        end else begin
            sif_b.sclk = s; sif_b.ncs = n; sif_b.copi = c;
        end
    endtask

    function automatic logic [95:0] model_flat(input int d);
        logic [95:0] f;
        f = '0;
        if (d == 0) for (int i = 0; i < 5; i++) f[i*8 +: 8] = ma[i];
        else        for (int i = 0; i < 8; i++) f[i*12 +: 12] = mb[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) ma[i] = '0;
        for (int i = 0; i < 8; i++) mb[i] = '0;
        exp_wa[0] = 0; exp_wa[1] = 0;
        exp_err[0] = 0; exp_err[1] = 0;
    endtask

    task automatic check_idle(input int d, input string tag);
        if (d == 0) begin
            chk({tag, "_regs_a"}, 128'(regs_a), 128'(model_flat(0)));
            chk({tag, "_busy_a"}, 128'(busy_a), 128'(0));
            chk({tag, "_oe_a"}, 128'(sif_a.cipo_oe), 128'(0));
            chk({tag, "_cipo_a"}, 128'(sif_a.cipo), 128'(0));
            chk({tag, "_waddr_a"}, 128'(wa_a), 128'(exp_wa[0]));
`ifdef SPI_REG_BANK_ERR_CNT_EN
            chk({tag, "_err_a"}, 128'(err_a), 128'(exp_err[0]));
`endif
        end else begin
            chk({tag, "_regs_b"}, 128'(regs_b), 128'(model_flat(1)));
            chk({tag, "_busy_b"}, 128'(busy_b), 128'(0));
            chk({tag, "_oe_b"}, 128'(sif_b.cipo_oe), 128'(0));
            chk({tag, "_waddr_b"}, 128'(wa_b), 128'(exp_wa[1]));
`ifdef SPI_REG_BANK_ERR_CNT_EN
            chk({tag, "_err_b"}, 128'(err_b), 128'(exp_err[1]));
`endif
        end
    endtask

    // Sends n bits of {rw,addr,data} MSB first (zeros beyond the frame), then checks.
    task automatic run_frame(input int d, input logic rw, input int addr,
                             input int data, input int n, input string tag);
        int aw, dw, nr, s0, s1, exp_s;
        logic [15:0] frame, rd, exp_rd;
        logic b, oe_ok, full, inr;
        aw = (d == 0) ? 7 : 3;
        dw = (d == 0) ? 8 : 12;
        nr = (d == 0) ? 5 : 8;
        frame = (d == 0) ? {rw, 7'(addr), 8'(data)} : {rw, 3'(addr), 12'(data)};
        full = (n == 16);
        inr = (addr < nr);
        exp_rd = '0;
        if (inr) exp_rd = (d == 0) ? 16'(ma[addr]) : 16'(mb[addr]);
        s0 = (d == 0) ? strb_cnt_a : strb_cnt_b;
        rd = '0;
        oe_ok = 1'b1;
        pins(d, 1'b0, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        for (int k = 0; k < n; k++) begin
            b = (k < 16) ? frame[15-k] : 1'b0;
            pins(d, 1'b0, 1'b0, b);
            repeat (4) @(posedge clk);
            #1;
            if (k == 0) chk({tag, "_busy"}, 128'((d == 0) ? busy_a : busy_b), 128'(1));
            if (k >= 1 + aw && k < 1 + aw + dw) begin
                rd = {rd[14:0], (d == 0) ? sif_a.cipo : sif_b.cipo};
                if (((d == 0) ? sif_a.cipo_oe : sif_b.cipo_oe) !== 1'b1) oe_ok = 1'b0;
            end
            pins(d, 1'b1, 1'b0, b);
            repeat (8) @(posedge clk);
            pins(d, 1'b0, 1'b0, b);
            repeat (4) @(posedge clk);
        end
        pins(d, 1'b0, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        exp_s = 0;
        if (full && rw && inr) begin
            exp_s = 1;
            exp_wa[d] = addr;
            if (d == 0) ma[addr] = 8'(data);
            else        mb[addr] = 12'(data);
        end
        if (n > 0 && !(full && inr) && exp_err[d] < 255) exp_err[d]++;
        s1 = (d == 0) ? strb_cnt_a : strb_cnt_b;
        chk({tag, "_strobes"}, 128'(s1 - s0), 128'(exp_s));
        if (!rw && n >= 1 + aw + dw) begin
            chk({tag, "_rdata"}, 128'(rd), 128'(exp_rd));
            chk({tag, "_rd_oe"}, 128'(oe_ok), 128'(1));
        end
        check_idle(d, tag);
    endtask

    initial begin
        int rw, addr, data, n, sel;
        model_reset();
        pins(0, 1'b0, 1'b1, 1'b0);
        pins(1, 1'b0, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check_idle(0, "por");
        check_idle(1, "por");
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        run_frame(0, 1'b1, 2, 8'hA5, 16, "wr_reg2");
        run_frame(0, 1'b1, 1, 8'h5A, 15, "short15");
        run_frame(0, 1'b1, 1, 8'h5A, 17, "long17");
        run_frame(0, 1'b1, 5, 8'hFF, 16, "oor_wr");
        run_frame(0, 1'b0, 0, 0, 0, "glitch");
        run_frame(0, 1'b1, 4, 8'h3C, 16, "wr_reg4");
        run_frame(0, 1'b0, 4, 8'h00, 16, "rd_reg4");
        run_frame(0, 1'b0, 6, 8'h00, 16, "rd_oor");
        run_frame(0, 1'b1, 0, 8'hFF, 16, "wr_reg0");

        run_frame(1, 1'b1, 7, 12'hABC, 16, "b_wr7");
        chk("b_reg7_slice", 128'(regs_b[95:84]), 128'(12'hABC));
        run_frame(1, 1'b0, 7, 0, 16, "b_rd7");
        run_frame(1, 1'b1, 0, 12'h801, 16, "b_wr0");
        run_frame(1, 1'b0, 0, 0, 16, "b_rd0");

        for (int i = 0; i < 24; i++) begin
            rw = int'($urandom_range(0, 1));
            addr = int'($urandom_range(0, 6));
            data = int'($urandom_range(0, 255));
            sel = int'($urandom_range(0, 5));
            n = (sel == 0) ? 15 : (sel == 1) ? 17 : (sel == 2) ? int'($urandom_range(1, 14)) : 16;
            run_frame(0, rw[0], addr, data, n, "rnd_a");
        end
        for (int i = 0; i < 10; i++) begin
            rw = int'($urandom_range(0, 1));
            addr = int'($urandom_range(0, 7));
            data = int'($urandom_range(0, 4095));
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 17)) : 16;
            run_frame(1, rw[0], addr, data, n, "rnd_b");
        end

        // Reset asserted part way through a write frame.
        pins(0, 1'b0, 1'b0, 1'b1);
        repeat (6) @(posedge clk);
        repeat (3) begin
            pins(0, 1'b1, 1'b0, 1'b1);
            repeat (8) @(posedge clk);
            pins(0, 1'b0, 1'b0, 1'b1);
            repeat (8) @(posedge clk);
        end
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_idle(0, "midrst");
        check_idle(1, "midrst");
        chk("midrst_strobe", 128'(strb_a), 128'(0));
        pins(0, 1'b0, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        run_frame(0, 1'b1, 3, 8'h77, 16, "post_rst_wr");
        run_frame(0, 1'b0, 3, 0, 16, "post_rst_rd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
